// File: rtl/rv_alu_pkg.sv
// Shared ALU definitions: operation encoding, default datapath width and
// the layout of one add/sub pipeline stage at that width.
package rv_alu_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } addsub_op_t;

    // One stage of the chunked adder: result chunks below the stage index are
    // final, operand chunks at and above it are still waiting to be added.
    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] res;
        logic                  carry;
    } addsub_stage_t;

endpackage

// File: rtl/addsub_slice.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
module addsub_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract: the WIDTH-bit operation is split into STAGES chunks,
// one chunk added per cycle with the carry registered between stages.
module pipe_addsub
    import rv_alu_pkg::*;
#(
    parameter int WIDTH  = DATA_WIDTH,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if (WIDTH % STAGES != 0) begin : g_bad_split
        $error("pipe_addsub: WIDTH must be a multiple of STAGES");
    end

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             carry;
    } stage_t;

    stage_t           src [STAGES];
    stage_t           nxt [STAGES];
    stage_t           stg [STAGES];
    logic [CHUNK-1:0] sum [STAGES];
    logic             cout [STAGES];
    logic             advance;
    logic             ovf_d;

    // Handshake: an operand transfer happens on a rising edge with in_valid && in_ready,
    // a result completes with out_valid && out_ready. The whole pipe moves as one unit
    // whenever the output register is empty or being drained, so in_ready is exactly that.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        src[0].valid = in_valid;
        src[0].a     = in_1;
        src[0].b     = (addsub_op_t'(sub) == OP_SUB) ? ~in_2 : in_2;
        src[0].res   = '0;
        src[0].carry = sub;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = stg[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        addsub_slice #(.CHUNK(CHUNK)) u_slice (
            .a   (src[k].a[k*CHUNK +: CHUNK]),
            .b   (src[k].b[k*CHUNK +: CHUNK]),
            .cin (src[k].carry),
            .sum (sum[k]),
            .cout(cout[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt[k]                        = src[k];
            nxt[k].res[k*CHUNK +: CHUNK]  = sum[k];
            nxt[k].carry                  = cout[k];
        end
    end

    assign ovf_d = (nxt[LAST].a[WIDTH-1] == nxt[LAST].b[WIDTH-1]) &&
                   (nxt[LAST].res[WIDTH-1] != nxt[LAST].a[WIDTH-1]);

    // The last stage is the output register; a bubble only clears its valid so the
    // data outputs keep the last delivered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                stg[k] <= '0;
            end
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                if (k < LAST || nxt[k].valid) begin
                    stg[k] <= nxt[k];
                end else begin
                    stg[k].valid <= 1'b0;
                end
            end
            if (nxt[LAST].valid) begin
                overflow <= ovf_d;
                zero     <= ~|nxt[LAST].res;
            end
        end
    end

    assign out_valid = stg[LAST].valid;
    assign out       = stg[LAST].res;
    assign carry_out = stg[LAST].carry;

endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub: driver pushes expected results from an
// arithmetic reference model, a negedge monitor pops and compares them.
module tb_pipe_addsub;

    localparam int W = 32;
    localparam int S = 4;
    localparam longint SMAX = (64'sd1 <<< (W-1)) - 64'sd1;
    localparam longint SMIN = -(64'sd1 <<< (W-1));

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_1;
    logic [W-1:0] in_2;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    logic [W+2:0] exp_q[$];
    int           done_cyc[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    bit           bp_en = 1'b0;

    pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_1     (in_1),
        .in_2     (in_2),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .carry_out(carry_out),
        .overflow (overflow),
        .zero     (zero)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // reference model: {result, carry, overflow, zero}
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        logic [W-1:0] r;
        logic         c;
        logic         v;
        longint       sr;
        if (s) begin
            r  = a - b;
            c  = (a >= b);
            sr = longint'($signed(a)) - longint'($signed(b));
        end else begin
            {c, r} = {1'b0, a} + {1'b0, b};
            sr     = longint'($signed(a)) + longint'($signed(b));
        end
        v = (sr > SMAX) || (sr < SMIN);
        return {r, c, v, (r == '0)};
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // driver tasks
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int waited = 0;
        in_valid = 1'b1;
        in_1     = a;
        in_2     = b;
        sub      = s;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
        end else begin
            exp_q.push_back(model(a, b, s));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results outstanding expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic latency_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                              input string name);
        send(a, b, s);
        idle();
        for (int k = 0; k < S; k++) begin
            @(negedge clk);
            check(name, 64'(out_valid), 64'(k == S-1));
        end
        drain();
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_valid"}, 64'(out_valid), 64'd0);
        check({name, "_out"}, 64'(out), 64'd0);
        check({name, "_flags"}, 64'({carry_out, overflow, zero}), 64'd0);
    endtask

    // scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got out=0x%0h expected no result", out);
                    end else begin
                        check("result", 64'({out, carry_out, overflow, zero}), 64'(exp_q[0]));
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            done_cyc.push_back(cyc);
                        end
                    end
                end
            end
        end
    end

    // random backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_1      = '0;
        in_2      = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // directed corners
        latency_op(32'hFFFF_FFFF, 32'h1, 1'b0, "lat_add_wrap");
        send(32'd5, 32'd7, 1'b1);
        send(32'h8000_0000, 32'h1, 1'b1);
        send(32'h7FFF_FFFF, 32'h1, 1'b0);
        send(32'h00FF_FFFF, 32'h1, 1'b0);
        send(32'h1234_5678, 32'h1234_5678, 1'b1);
        idle();
        drain();

        // back-to-back random ops
        done_cyc.delete();
        for (int i = 0; i < 8; i++) send(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
        idle();
        drain();
        check("b2b_count", 64'(done_cyc.size()), 64'd8);
        if (done_cyc.size() == 8) begin
            for (int i = 1; i < 8; i++) begin
                check("b2b_consecutive", 64'(done_cyc[i] - done_cyc[i-1]), 64'd1);
            end
        end

        // full pipe held by the consumer
        out_ready = 1'b0;
        for (int i = 0; i < S; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        done_cyc.delete();
        out_ready = 1'b1;
        drain();
        check("stall_drain_count", 64'(done_cyc.size()), 64'(S));

        // reset with ops in flight, in_valid high during reset
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
        reset    = 1'b1;
        in_1     = $urandom;
        in_2     = $urandom;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        @(negedge clk);
        check_reset_values("mid_reset");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        latency_op($urandom, $urandom, 1'b1, "lat_after_reset");

        // random traffic with random gaps and backpressure
        bp_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk);
                #1;
            end
            send(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
        end
        idle();
        drain();
        bp_en     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
